// File: rtl/wb_stage.sv
// wb_stage: write-back stage that waits for late load data, selects the result,
// drives the register file write port with same-cycle bypass, and counts retires.
module wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_pc_plus1,
  input  logic [DATA_W-1:0] mem_imm,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [15:0]       retired_count
);
  typedef enum logic [1:0] {EMPTY, WAIT_LOAD, FULL} state_t;
  state_t state_q, state_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d, sel_result;
  logic [15:0] cnt_q, cnt_d;
  logic accept, is_load, load_arrives;
  assign mem_ready    = state_q != WAIT_LOAD;
  assign accept       = mem_valid && mem_ready;
  assign is_load      = mem_wb_sel == 2'b01;
  assign load_arrives = state_q == WAIT_LOAD && load_valid;
  always_comb begin
    sel_result = mem_wb_sel == 2'b00 ? mem_alu_result :
                 mem_wb_sel == 2'b10 ? mem_pc_plus1 :
                 mem_wb_sel == 2'b11 ? mem_imm : load_data;
    state_d = accept ? ((is_load && !load_valid) ? WAIT_LOAD : FULL) :
              state_q == WAIT_LOAD ? (load_valid ? FULL : WAIT_LOAD) : EMPTY;
    wr_d    = accept ? mem_reg_write : wr_q;
    dest_d  = accept ? mem_dest : dest_q;
    data_d  = accept ? sel_result : load_arrives ? load_data : data_q;
    cnt_d   = cnt_q + {15'd0, state_q == FULL};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wr_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  // reset gates the write combinationally so a dropped instruction never commits
  assign reg_write_en   = state_q == FULL && wr_q && rst_n;
  assign reg_write_addr = reg_write_en ? dest_q : '0;
  assign reg_write_data = reg_write_en ? data_q : '0;
  assign fwd_data1      = (reg_write_en && rd_addr1 == dest_q) ? data_q : rf_data1;
  assign fwd_data2      = (reg_write_en && rd_addr2 == dest_q) ? data_q : rf_data2;
  assign retired_count  = cnt_q;
endmodule
